// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, baud divider helper and legal frame-format limits.
// Optional parity state present only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } tx_state_e;
`endif

  // Clocks per bit, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with show-ahead dout; shared by the UART TX and RX paths.
// Latency: push visible on dout/level the cycle after; backpressure: push ignored while full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   LVL_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_FULL  = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_level == LVL_FULL);
  assign empty = (r_level == '0);
  assign level = r_level;

endmodule

// File: rtl/uart_tx_stream.sv
// Buffered UART transmitter: valid/ready words queued in sync_fifo, sent back-to-back; parity via UART_TX_PARITY_EN.
// Latency: start bit on tx one clock after accept into an idle block; backpressure: tx_ready low while FIFO full.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_BITS-1:0]            tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int TW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam int IW  = 4;

  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(DIV - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [IW-1:0] DATA_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST  = IW'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_stream: CLK_HZ/BAUD yields fewer than 2 clocks per bit");
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_tx_stream: DATA_BITS out of range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_tx_stream: STOP_BITS out of range");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx_stream: PARITY_ODD must be 0 or 1");
  end

  tx_state_e            r_state;
  tx_state_e            w_state_nxt;
  logic [TW-1:0]        r_timer;
  logic [TW-1:0]        w_timer_nxt;
  logic [IW-1:0]        r_idx;
  logic [IW-1:0]        w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 w_tick;
  logic                 w_load;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_full;
  logic [DATA_BITS-1:0] w_fifo_dout;
`ifdef UART_TX_PARITY_EN
  logic                 r_par;
  logic                 w_par_nxt;
`endif

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .pop   (w_pop),
    .din   (tx_data),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  assign w_tick = (r_timer == TIMER_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = w_tick ? '0 : r_timer + TIMER_ONE;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif

    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = '0;
        if (!w_empty) w_load = 1'b1;
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt = ST_DATA;
          w_idx_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_idx == DATA_LAST) begin
            w_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + IDX_ONE;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_state_nxt = ST_STOP;
          w_idx_nxt   = '0;
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          if (r_idx != STOP_LAST) begin
            w_idx_nxt = r_idx + IDX_ONE;
          end else if (!w_empty) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
      end
    endcase

    // Loading from IDLE or from the final stop tick share one path, so frames chain with no gap.
    if (w_load) begin
      w_pop       = 1'b1;
      w_state_nxt = ST_START;
      w_timer_nxt = '0;
      w_idx_nxt   = '0;
      w_shift_nxt = w_fifo_dout;
`ifdef UART_TX_PARITY_EN
      w_par_nxt   = (^w_fifo_dout) ^ (PARITY_ODD != 0);
`endif
    end

    case (w_state_nxt)
      ST_START:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_nxt = w_par_nxt;
`endif
      default:   w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  assign tx       = r_tx;
  assign tx_ready = !w_full;
  assign busy     = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: frame-level queue model checks tx/level/ready/busy every clock.
// A second instance exercises the 7-bit, two-stop-bit, odd-parity frame format.
module tb_uart_tx_stream;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 250_000;
  localparam int DIV    = 4;
  localparam int DEPTH  = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBIT1 = 1 + 8 + PAR + 1;
  localparam int NBIT2 = 1 + 7 + PAR + 2;
  localparam int F1    = NBIT1 * DIV;
  localparam int F2    = NBIT2 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy;
  logic [4:0] fifo_level;
  logic [6:0] tx_data2 = 7'h00;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready2, tx2, busy2;
  logic [4:0] fifo_level2;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  uart_tx_stream #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .STOP_BITS(1),
    .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)
  ) u_dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_level(fifo_level)
  );

  uart_tx_stream #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .STOP_BITS(2),
    .FIFO_DEPTH(DEPTH), .PARITY_ODD(1)
  ) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx(tx2), .busy(busy2), .fifo_level(fifo_level2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit k of the result is the k-th bit on the line: start, data LSB first, optional parity, stops.
  function automatic logic [15:0] frame_bits(input logic [8:0] d, input int nb, input bit par_en,
                                             input bit odd);
    logic [15:0] f;
    bit          x;
    f    = '1;
    f[0] = 1'b0;
    x    = odd;
    for (int i = 0; i < nb; i++) begin
      f[1 + i] = d[i];
      x        = x ^ d[i];
    end
    if (par_en) f[1 + nb] = x;
    return f;
  endfunction

  // Reference model: words waiting in the queue and line samples left in the frame being sent.
  logic [7:0] pq[$];
  bit         fq[$];
  logic       acc_vld = 1'b0;
  logic [7:0] acc_dat = 8'h00;

  task automatic load_frame(input logic [7:0] w);
    logic [15:0] f;
    f = frame_bits({1'b0, w}, 8, PAR != 0, 1'b0);
    for (int i = 0; i < NBIT1; i++)
      repeat (DIV) fq.push_back(f[i]);
  endtask

  always @(posedge clk) begin
    acc_vld = rst && tx_valid && tx_ready;
    acc_dat = tx_data;
  end

  always @(negedge clk) begin
    bit exp_tx;
    bit in_frame;
    if (!rst) begin
      pq.delete();
      fq.delete();
      chk("rst_tx", tx, 1);
      chk("rst_level", fifo_level, 0);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);
    end else begin
      exp_tx   = 1'b1;
      in_frame = 1'b0;
      if (fq.size() == 0 && pq.size() != 0) load_frame(pq.pop_front());
      if (fq.size() != 0) begin
        exp_tx   = fq.pop_front();
        in_frame = 1'b1;
      end
      if (acc_vld) pq.push_back(acc_dat);
      chk("line_tx", tx, exp_tx);
      chk("level", fifo_level, pq.size());
      chk("ready", tx_ready, pq.size() < DEPTH);
      chk("busy", busy, in_frame || pq.size() != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  logic cap [128];

  task automatic send1(input logic [7:0] d);
    int n;
    tx_data  = d;
    tx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!acc_vld && n < 500);
    tx_valid = 1'b0;
    chk("send_accept", acc_vld, 1);
  endtask

  task automatic send_burst(input int cnt, input logic [7:0] first, output int first_full);
    int n;
    int acc;
    acc        = 0;
    n          = 0;
    first_full = -1;
    tx_data    = first;
    tx_valid   = 1'b1;
    while (acc < cnt && n < 5000) begin
      @(negedge clk);
      n++;
      if (acc_vld) begin
        acc++;
        tx_data = 8'($urandom);
      end
      if (!tx_ready && first_full < 0) first_full = acc;
    end
    tx_valid = 1'b0;
    chk("burst_accepts", acc, cnt);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || fifo_level != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic capture(output int len);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      cap[n] = tx;
      n++;
    end while (busy && n < 120);
    len = n;
  endtask

  task automatic check_frame8(input string tag, input logic [7:0] want);
    int         len;
    logic [7:0] got;
    capture(len);
    for (int i = 0; i < 8; i++) got[i] = cap[(1 + i) * DIV + DIV / 2];
    chk({tag, "_len"}, len, F1 + 1);
    chk({tag, "_first"}, cap[0], 0);
    chk({tag, "_data"}, got, want);
    chk({tag, "_stop"}, cap[(9 + PAR) * DIV + DIV / 2], 1);
`ifdef UART_TX_PARITY_EN
    chk({tag, "_par"}, cap[9 * DIV + DIV / 2], ^want);
`endif
  endtask

  initial begin
    int          ff;
    int          n;
    logic [15:0] f2;

    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);

    // Single word into an idle block, decoded from mid-bit samples.
    send1(8'hA5);
    check_frame8("a5", 8'hA5);
    wait_idle();

    // Twenty words with valid held: 16 queued plus one in flight before backpressure.
    send_burst(20, 8'($urandom), ff);
    chk("full_after", ff, 17);
    wait_idle();
    chk("burst_level_end", fifo_level, 0);

    // Push coinciding with the pop at the first frame boundary while three words wait.
    send_burst(4, 8'($urandom), ff);
    repeat (37) @(negedge clk);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("pp_accept", acc_vld, 1);
    chk("pp_level", fifo_level, 3);
    wait_idle();

    // Reset in the middle of the data bits of 0x3C with five words queued behind it.
    send_burst(6, 8'h3C, ff);
    chk("mr_level_before", fifo_level, 5);
    repeat (12) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mr_tx", tx, 1);
    chk("mr_level", fifo_level, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ready", tx_ready, 1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    send1(8'h81);
    check_frame8("r81", 8'h81);
    wait_idle();

    // Random words with random gaps, including gaps long enough to go idle.
    for (int i = 0; i < 30; i++) begin
      send1(8'($urandom));
      n = ($urandom_range(0, 5) == 0) ? 45 : $urandom_range(0, 3);
      repeat (n) @(negedge clk);
    end
    wait_idle();

    // Second format: 7 data bits, two stops, odd parity when compiled in.
    chk("d2_ready", tx_ready2, 1);
    tx_data2  = 7'h7F;
    tx_valid2 = 1'b1;
    @(negedge clk);
    tx_valid2 = 1'b0;
    f2 = frame_bits({2'b00, 7'h7F}, 7, PAR != 0, 1'b1);
    n  = 0;
    do begin
      @(negedge clk);
      cap[n] = tx2;
      n++;
    end while (busy2 && n < 120);
    chk("d2_len", n, F2 + 1);
    for (int i = 0; i < F2; i++) chk("d2_tx", cap[i], f2[i / DIV]);
`ifdef UART_TX_PARITY_EN
    chk("d2_par", cap[8 * DIV + DIV / 2], 0);
`endif
    chk("d2_stop2", cap[F2 - 1], 1);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Buffered, parametrised UART transmitter: accepts data words on a valid/ready stream, queues them in an internal FIFO, and serialises them back-to-back on a single TX line. Sits between on-chip producers and the UART_TX pad, under the top-level `chip` module. Clocked from the 100 MHz board clock and driven by the reset generator output. Succeeds the fixed-function transmitter with configurable baud rate, frame format, buffering and flow control.

## Interface
- CLK_HZ, 100_000_000, input clock frequency in Hz
- BAUD, 115_200, line rate; DIV = (CLK_HZ + BAUD/2) / BAUD clocks per bit; elaboration error if DIV < 2
- DATA_BITS, 8, data bits per frame, legal 5..9
- STOP_BITS, 1, stop bits per frame, legal 1 or 2
- FIFO_DEPTH, 16, queue depth, power of two, ≥ 2
- PARITY_ODD, 0, parity sense when parity is compiled in (0 = even, 1 = odd)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- tx_data  in  DATA_BITS  word to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  FIFO not full; word accepted on rising edge when tx_valid && tx_ready
- tx  out  1  serial line, idle high
- busy  out  1  FIFO non-empty or frame in progress
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words queued (excludes the frame in flight)

## Operation
- Reset (rst low, async): tx=1, tx_ready=1, busy=0, fifo_level=0, FSM in IDLE, counters zero, FIFO emptied.
- FIFO: push on accept. Pop when the FSM loads a word. Push and pop in the same cycle leave the level unchanged. tx_ready is low only when level == FIFO_DEPTH. Writes while full are impossible by handshake; tx_valid held while tx_ready is low must not be lost.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty: pop into the shift register, clear the bit timer.
  - START drives 0 for DIV clocks, then DATA.
  - DATA sends DATA_BITS bits LSB first, DIV clocks each, then PARITY (if compiled in) or STOP.
  - PARITY drives the XOR of the data bits, inverted if PARITY_ODD, for DIV clocks.
  - STOP drives 1 for STOP_BITS*DIV clocks. On its last clock: if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Bit timer counts 0..DIV-1 and wraps; the bit index advances on wrap. Timer width is $clog2(DIV).
- tx is registered (no combinational path from FSM to pad).
- tx_data/tx_valid changes never affect a frame already loaded.

## Timing
- Accept at edge k into an empty FIFO with the FSM in IDLE: fifo_level=1 after k; pop at edge k+1; tx=0 from k+1.
- Frame length F = (1 + DATA_BITS + P + STOP_BITS) * DIV clocks, where P = 1 if parity is compiled in, else 0. Consecutive queued frames are exactly F apart.
- busy rises at the accept edge and falls on the edge that ends the final stop bit with the FIFO empty.
- Reset asserted mid-frame: tx=1 immediately (async); queued data is discarded.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state and bit are present, P=1, and PARITY_ODD selects the sense.
- UART_TX_PARITY_EN undefined: no PARITY state, P=0, PARITY_ODD is ignored, and the frame is 8N1-style.

## Structure
- Package uart_pkg holds:
  - the state enum type;
  - the function calc_div(clk_hz, baud);
  - the legal-range constants for DATA_BITS and STOP_BITS.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; ports clk, rst, push, pop, din, dout, full, empty, level) holds the queue. It is reused by the future RX path.

## Test plan
Bench configuration: CLK_HZ=1_000_000, BAUD=250_000 (DIV=4), DATA_BITS=8, STOP_BITS=1.
- Single word 0xA5 into an idle block → tx low 1 clock after accept, then bits 1,0,1,0,0,1,0,1, then stop; 40 clocks total (44 with parity; parity bit 0 for even).
- 20 words pushed with tx_valid held high → tx_ready drops after 16 queued plus 1 loaded; all 20 frames are sent with no idle gap; fifo_level returns to 0 and busy falls.
- Push and pop in the same cycle with level=3 → level stays 3; no word is lost or duplicated (scoreboard compare).
- rst pulsed low mid-DATA of word 0x3C with 5 words queued → tx=1 and level=0 immediately; the next word 0x81 pushed after release is sent correctly.
- STOP_BITS=2, DATA_BITS=7, word 0x7F, parity compiled in with PARITY_ODD=1 → 7 ones followed by parity 0, then 2*DIV high clocks.
